// File: rtl/gsu_pkg.sv
// gsu_pkg: shared encodings and sizes for the GSU instruction cache
package gsu_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_DIRECT,
        ST_RESP
    } state_t;
    localparam logic [9:0] MMIO_CACHE_BASE = 10'h100;
    localparam int CACHE_BYTES = 512;
    localparam int LINE_BYTES  = 16;
endpackage

// File: rtl/gsu_cache_ram.sv
// gsu_cache_ram: single-port synchronous RAM, read-first, one-cycle read latency
module gsu_cache_ram #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // one access per cycle: optional write plus registered read of the old contents
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wd;
        rd <= mem[addr];
    end
endmodule

// File: rtl/gsu_cache_ctrl.sv
// gsu_cache_ctrl: instruction cache lookup/fill/bypass sequencer with SNES MMIO access to the cache RAM
module gsu_cache_ctrl
    import gsu_pkg::*;
#(
    parameter int LINE_AW  = 4,
    parameter int CACHE_AW = 9
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic [7:0]  fetch_bank,
    input  logic [11:0] cbr,
    input  logic        flush,
    output logic        fetch_ack,
    output logic [7:0]  fetch_data,
    output logic        rom_req,
    output logic [23:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    input  logic        snes_sel,
    input  logic        snes_we,
    input  logic [8:0]  snes_addr,
    input  logic [7:0]  snes_di,
    output logic [7:0]  snes_do,
    output logic        busy
);
    localparam int NL = 1 << (CACHE_AW - LINE_AW);

    state_t state, state_n;
    logic [NL-1:0] valid, valid_n;
    logic [CACHE_AW-1:0] off_q, ram_addr, hold_addr;
    logic [CACHE_AW-LINE_AW-1:0] line;
    logic [LINE_AW-1:0] idx;
    logic [7:0] ram_wd, ram_rd, hold_data, snes_hold;
    logic [15:0] base, off, fill_addr;
    logic ram_we, hold_v, lk_ok, flushed, snes_rd_q;
    logic in_win, fill_wr, to_hold, accept, fill_last;

    assign base      = {cbr, 4'h0};
    assign off       = fetch_addr - base;
    assign in_win    = off < 16'(CACHE_BYTES);
    assign line      = off_q[CACHE_AW-1:LINE_AW];
    assign fill_addr = base + 16'({line, idx});
    assign fill_wr   = state == ST_FILL && rom_ack;
    // a fill byte goes straight to RAM only when the port is free and nothing older is buffered
    assign to_hold   = fill_wr && (snes_sel || hold_v);
    assign accept    = state == ST_IDLE && fetch_req && !snes_sel && !hold_v;
    assign fill_last = fill_wr && idx == '1;

    gsu_cache_ram #(.AW(CACHE_AW), .DW(8)) u_ram (
        .clk  (clkin),
        .we   (ram_we),
        .addr (ram_addr),
        .wd   (ram_wd),
        .rd   (ram_rd)
    );

    // RAM port arbitration: SNES, then buffered fill byte, then live fill byte, then core lookup read
    always_comb begin
        ram_addr = snes_sel ? snes_addr : hold_v ? hold_addr : fill_wr ? {line, idx} :
                   state == ST_IDLE ? off[CACHE_AW-1:0] : off_q;
        ram_we   = snes_sel ? snes_we : (hold_v || fill_wr);
        ram_wd   = snes_sel ? snes_di : hold_v ? hold_data : rom_data;
    end

    // valid bits: SNES write of a line's last byte validates it, a clean fill validates it, flush beats both
    always_comb begin
        valid_n = valid;
        if (snes_sel && snes_we && snes_addr[LINE_AW-1:0] == '1) valid_n[snes_addr[CACHE_AW-1:LINE_AW]] = 1'b1;
        if (fill_last && !flushed) valid_n[line] = 1'b1;
        if (flush) valid_n = '0;
    end

    // state register
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // next state; a lookup only decides on data read by the core in the previous cycle
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (accept) state_n = in_win ? ST_LOOKUP : ST_DIRECT;
            ST_LOOKUP: if (lk_ok && !snes_sel) state_n = valid[line] ? ST_RESP : ST_FILL;
            ST_FILL:   if (fill_last) state_n = ST_RESP;
            ST_DIRECT: if (rom_ack) state_n = ST_RESP;
            ST_RESP:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // outputs decoded from state and the SNES read path
    always_comb begin
        fetch_ack = state == ST_RESP;
        busy      = state != ST_IDLE;
        snes_do   = snes_rd_q ? ram_rd : snes_hold;
    end

    // datapath registers: ROM request/address, fill index, holding buffer, captured fetch byte
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= '0;
            fetch_data <= '0;
            rom_req    <= 1'b0;
            rom_addr   <= '0;
            off_q      <= '0;
            idx        <= '0;
            hold_v     <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            lk_ok      <= 1'b0;
            flushed    <= 1'b0;
            snes_rd_q  <= 1'b0;
            snes_hold  <= '0;
        end else begin
            valid     <= valid_n;
            lk_ok     <= !snes_sel && !hold_v && !fill_wr;
            snes_rd_q <= snes_sel && !snes_we;
            hold_v    <= to_hold || (hold_v && snes_sel);
            if (snes_rd_q) snes_hold <= ram_rd;
            if (to_hold) begin
                hold_addr <= {line, idx};
                hold_data <= rom_data;
            end
            if (accept) off_q <= off[CACHE_AW-1:0];
            if (accept && !in_win) begin
                rom_req  <= 1'b1;
                rom_addr <= {fetch_bank, fetch_addr};
            end
            if (state == ST_LOOKUP && state_n == ST_RESP) fetch_data <= ram_rd;
            if (state == ST_LOOKUP && state_n == ST_FILL) begin
                idx      <= '0;
                flushed  <= 1'b0;
                rom_req  <= 1'b1;
                rom_addr <= {fetch_bank, base + 16'({line, {LINE_AW{1'b0}}})};
            end
            if (state == ST_FILL && flush) flushed <= 1'b1;
            if (fill_wr) begin
                idx      <= idx + 1'b1;
                rom_addr <= {fetch_bank, fill_addr + 16'd1};
                if (idx == off_q[LINE_AW-1:0]) fetch_data <= rom_data;
                if (fill_last) rom_req <= 1'b0;
            end
            if (state == ST_DIRECT && rom_ack) begin
                fetch_data <= rom_data;
                rom_req    <= 1'b0;
            end
        end
    end
endmodule
